fp_mult_mantissa_pipe: RTL and testbench
========================================

# fp_mult_mantissa_pipe

Pipelined, parametrised mantissa multiplier for the FPMult datapath. It replaces the single-cycle 24x24 execute stage with a DSP48E1-tiled pipeline. Operand B is split into CHUNK-bit slices, one unsigned multiply runs per slice, and partial products are accumulated through a shifted cascade. The block sits between the FPMult prepare and normalise stages and adds a valid/ready handshake with backpressure.

## Interface
- MW, 24: mantissa width including the hidden bit; legal range 8..53.
- CHUNK, 17: B-slice width; matches the DSP48E1 unsigned port width; legal range 8..17.
- NB, derived = ceil(MW/CHUNK): number of B slices; not overridable.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  Ma/Mb are presented this cycle.
- in_ready  out  1  block accepts an operand pair this cycle.
- Ma  in  MW  mantissa A, unsigned.
- Mb  in  MW  mantissa B, unsigned.
- out_valid  out  1  Mp/norm hold a result.
- out_ready  in  1  downstream consumes the result this cycle.
- Mp  out  2*MW  exact unsigned product Ma*Mb.
- norm  out  1  equals Mp[2*MW-1]; when 1, the product lies in [2,4) and the normaliser must shift right.

## Operation
- Pipeline stages, each with its own valid bit:
  - S0 registers Ma and Mb.
  - S1 computes the NB partial products P_k = Ma * Mb[k*CHUNK +: CHUNK]. The top slice is zero-extended.
  - S2..S(NB+1) are accumulate stages. Stage j adds P_(j-2) << ((j-2)*CHUNK) to the running sum. All operands are held at 2*MW+CHUNK bits internally; the result is truncated to 2*MW bits at output, with no loss.
  - The last stage drives Mp, norm and out_valid directly from registers.
- Global advance: en = ~out_valid | out_ready. in_ready = en, purely combinational.
- When en = 1, every stage register loads from its predecessor, and S0 loads Ma, Mb and in_valid.
- When en = 0, all stage registers hold, including data and valid bits.
- A transfer occurs on the input side when in_valid & in_ready, and on the output side when out_valid & out_ready.
- Bubbles are not collapsed. An invalid slot travels through the pipeline like data.
- Data registers of invalid slots may hold any value. Mp is meaningful only while out_valid = 1.
- Arithmetic is exact for all inputs. No rounding, sticky or exponent handling is done here.

## Timing
- Reset: all valid bits are 0, so out_valid = 0. Mp = 0, norm = 0, and all data registers are 0.
- While rst is high, in_ready = 1 because en = ~out_valid. Nothing is captured until rst falls.
- Latency L = NB + 2 cycles from input transfer to out_valid. With the defaults (MW = 24, NB = 2), L = 4.
- Throughput is one result per cycle while out_ready = 1.
- Backpressure:
  - If out_valid = 1 and out_ready = 0, in_ready drops in the same cycle and the whole pipeline freezes.
  - Mp is held stable until the cycle after out_ready is seen high.
- Simultaneous output and input transfer in the same cycle is legal; no slot is lost or duplicated.
- Reset asserted mid-operation clears all in-flight results immediately. No partial result appears after reset is released.
- Results leave in issue order, and no reordering is possible.

## Test plan
- Defaults, out_ready held 1; issue back-to-back 0x800000*0x800000, 0xC00000*0xA00000, 0x900000*0x980000, 0xC00000*0xC00000. Required outputs, one per cycle starting 4 cycles after the first issue:
  - 0x400000000000, norm = 0
  - 0x780000000000, norm = 0
  - 0x558000000000, norm = 0
  - 0x900000000000, norm = 1
- Boundary operands: 0xFFFFFF*0xFFFFFF -> 0xFFFFFE000001 with norm = 1. 0x000000*0xFFFFFF -> 0.
- Backpressure: stream 6 operand pairs and hold out_ready = 0 for 5 cycles after the first out_valid. Required response:
  - in_ready = 0 throughout the stall.
  - Mp is stable during the stall.
  - All 6 products emerge in order, with none dropped or duplicated.
- Reset during flight: issue 3 pairs, then pulse rst on cycle 2. Required response:
  - out_valid = 0 immediately and stays 0 until new inputs arrive.
  - The first post-reset pair emerges exactly 4 cycles after its issue.
- Parameter sweep at MW = 53, CHUNK = 17 (NB = 4, L = 6), using 1000 random pairs plus alternating in_valid gaps. Every Mp must match the reference product Ma*Mb, and the gaps must appear as out_valid = 0 slots.
- Parameter sweep at MW = 8, CHUNK = 17 (NB = 1, L = 3), using an exhaustive 256x256 input set. All products must be exact.

Source files
------------

// File: rtl/fp_mult_mantissa_pipe.sv
// Pipelined exact unsigned mantissa multiplier. B is cut into CHUNK-bit slices, one
// multiply runs per slice, and the partial products are summed through a shifted cascade.
module fp_mult_mantissa_pipe #(
    parameter int MW    = 24,
    parameter int CHUNK = 17
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [MW-1:0]   Ma,
    input  logic [MW-1:0]   Mb,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*MW-1:0] Mp,
    output logic            norm
);
    localparam int NB = (MW + CHUNK - 1) / CHUNK;
    localparam int BW = NB * CHUNK;
    localparam int PW = MW + CHUNK;
    localparam int AW = 2 * MW + CHUNK;

    logic             w_en;
    logic [NB+1:0]    r_vld;
    logic [MW-1:0]    r_a;
    logic [MW-1:0]    r_b;
    logic [BW-1:0]    w_b_pad;
    logic [AW-1:0]    w_sum [0:NB];
    logic [CHUNK-1:0] w_sum_hi;

    // One enable freezes every stage, bubbles included, so slot order and spacing never change.
    assign w_en     = ~r_vld[NB+1] | out_ready;
    assign in_ready = w_en;

    // NOTE: sequential state uses non-blocking assignments so every stage samples its
    // predecessor's pre-edge value; blocking here would collapse the pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_a   <= '0;
            r_b   <= '0;
        end else if (w_en) begin
            r_vld <= {r_vld[NB:0], in_valid};
            r_a   <= Ma;
            r_b   <= Mb;
        end
    end

    assign w_b_pad  = BW'(r_b);
    assign w_sum[0] = '0;

    for (genvar k = 0; k < NB; k++) begin : g_lane
        logic [PW-1:0] w_pp;
        logic [PW-1:0] r_dly [0:k];
        logic [AW-1:0] r_sum;

        assign w_pp = PW'(r_a) * PW'(w_b_pad[k*CHUNK +: CHUNK]);

        // Slice k waits k extra stages so it meets the running sum at accumulate stage k.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                // NOTE: these delay arrays are cleared on reset because the block must come
                // out of reset with every data register at zero, not just the valid bits.
                for (int i = 0; i <= k; i++) r_dly[i] <= '0;
                r_sum <= '0;
            end else if (w_en) begin
                r_dly[0] <= w_pp;
                for (int i = 1; i <= k; i++) r_dly[i] <= r_dly[i-1];
                r_sum <= w_sum[k] + (AW'(r_dly[k]) << (k * CHUNK));
            end
        end

        assign w_sum[k+1] = r_sum;
    end

    assign {w_sum_hi, Mp} = w_sum[NB];
    assign out_valid      = r_vld[NB+1];
    assign norm           = Mp[2*MW-1];

    // The full product always fits in 2*MW bits, so the guard bits are always zero.
    always_comb begin
        assert (w_sum_hi == '0);
    end
endmodule

// File: tb/tb_fp_mult_mantissa_pipe.sv
// Self-checking bench: default, MW=53 and MW=8 instances checked against plain
// multiplication, fixed latency and in-order delivery under backpressure and reset.
module tb_fp_mult_mantissa_pipe;
    localparam int L24 = 4;
    localparam int L53 = 6;
    localparam int L8  = 3;

    typedef struct {
        int           cyc;
        logic [105:0] prod;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    logic        iv24, ir24, ov24, or24, nm24;
    logic [23:0] a24, b24;
    logic [47:0] mp24;

    logic         iv53, ir53, ov53, or53, nm53;
    logic [52:0]  a53, b53;
    logic [105:0] mp53;

    logic        iv8, ir8, ov8, or8, nm8;
    logic [7:0]  a8, b8;
    logic [15:0] mp8;

    always #5 clk = ~clk;

    fp_mult_mantissa_pipe u_d24 (
        .clk(clk), .rst(rst), .in_valid(iv24), .in_ready(ir24), .Ma(a24), .Mb(b24),
        .out_valid(ov24), .out_ready(or24), .Mp(mp24), .norm(nm24)
    );

    fp_mult_mantissa_pipe #(.MW(53), .CHUNK(17)) u_d53 (
        .clk(clk), .rst(rst), .in_valid(iv53), .in_ready(ir53), .Ma(a53), .Mb(b53),
        .out_valid(ov53), .out_ready(or53), .Mp(mp53), .norm(nm53)
    );

    fp_mult_mantissa_pipe #(.MW(8), .CHUNK(17)) u_d8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .Ma(a8), .Mb(b8),
        .out_valid(ov8), .out_ready(or8), .Mp(mp8), .norm(nm8)
    );

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        iv24 = 1'b0; a24 = '0; b24 = '0; or24 = 1'b1;
        iv53 = 1'b0; a53 = '0; b53 = '0; or53 = 1'b1;
        iv8  = 1'b0; a8  = '0; b8  = '0; or8  = 1'b1;
        repeat (2) tick();
        #1;
        checks++; if (ov24 !== 1'b0) begin failures++; $display("FAIL reset_out_valid24: got %b expected 0", ov24); end
        checks++; if (mp24 !== '0)   begin failures++; $display("FAIL reset_mp24: got %h expected 0", mp24); end
        checks++; if (nm24 !== 1'b0) begin failures++; $display("FAIL reset_norm24: got %b expected 0", nm24); end
        checks++; if (ir24 !== 1'b1) begin failures++; $display("FAIL reset_in_ready24: got %b expected 1", ir24); end
        checks++; if (ov53 !== 1'b0 || mp53 !== '0) begin failures++; $display("FAIL reset_d53: got valid=%b mp=%h expected 0/0", ov53, mp53); end
        checks++; if (ov8 !== 1'b0 || mp8 !== '0)   begin failures++; $display("FAIL reset_d8: got valid=%b mp=%h expected 0/0", ov8, mp8); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [23:0] ta [4];
        logic [23:0] tb [4];
        logic [47:0] tp [4];
        logic        tn [4];
        ta = '{24'h800000, 24'hC00000, 24'h900000, 24'hC00000};
        tb = '{24'h800000, 24'hA00000, 24'h980000, 24'hC00000};
        tp = '{48'h400000000000, 48'h780000000000, 48'h558000000000, 48'h900000000000};
        tn = '{1'b0, 1'b0, 1'b0, 1'b1};
        or24 = 1'b1;
        for (int t = 0; t < 4 + L24 + 2; t++) begin
            iv24 = (t < 4);
            a24  = ta[t % 4];
            b24  = tb[t % 4];
            #1;
            checks++;
            if (t >= L24 && t < L24 + 4) begin
                if (ov24 !== 1'b1 || mp24 !== tp[t-L24] || nm24 !== tn[t-L24]) begin
                    failures++;
                    $display("FAIL b2b_result%0d: got valid=%b mp=%h norm=%b expected valid=1 mp=%h norm=%b",
                             t - L24, ov24, mp24, nm24, tp[t-L24], tn[t-L24]);
                end
            end else if (ov24 !== 1'b0) begin
                failures++;
                $display("FAIL b2b_idle t=%0d: got valid=%b expected 0", t, ov24);
            end
            tick();
        end
        iv24 = 1'b0;
    endtask

    task automatic test_boundary();
        logic [23:0] ta [2];
        logic [23:0] tb [2];
        logic [47:0] tp [2];
        logic        tn [2];
        ta = '{24'hFFFFFF, 24'h000000};
        tb = '{24'hFFFFFF, 24'hFFFFFF};
        tp = '{48'hFFFFFE000001, 48'h000000000000};
        tn = '{1'b1, 1'b0};
        for (int t = 0; t < L24 + 5; t++) begin
            iv24 = (t == 0 || t == 2);
            a24  = ta[(t / 2) % 2];
            b24  = tb[(t / 2) % 2];
            #1;
            checks++;
            if (t == L24 || t == L24 + 2) begin
                if (ov24 !== 1'b1 || mp24 !== tp[(t-L24)/2] || nm24 !== tn[(t-L24)/2]) begin
                    failures++;
                    $display("FAIL boundary%0d: got valid=%b mp=%h norm=%b expected valid=1 mp=%h norm=%b",
                             (t - L24) / 2, ov24, mp24, nm24, tp[(t-L24)/2], tn[(t-L24)/2]);
                end
            end else if (ov24 !== 1'b0) begin
                failures++;
                $display("FAIL boundary_gap t=%0d: got valid=%b expected 0", t, ov24);
            end
            tick();
        end
        iv24 = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [23:0] pa [6];
        logic [23:0] pb [6];
        logic [47:0] expq [$];
        logic [47:0] held;
        int sent = 0, got = 0, stall = 0, guard = 0;
        bit stalled = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pa[i] = 24'($urandom()) | 24'h800000;
            pb[i] = 24'($urandom()) | 24'h800000;
        end
        held = '0;
        while (got < 6 && guard < 80) begin
            if (ov24 === 1'b1 && !stalled) begin
                stalled = 1'b1;
                stall   = 5;
            end
            or24 = (stall == 0);
            iv24 = (sent < 6);
            a24  = pa[sent % 6];
            b24  = pb[sent % 6];
            #1;
            if (stall > 0) begin
                checks++;
                if (ir24 !== 1'b0) begin failures++; $display("FAIL stall_in_ready: got %b expected 0", ir24); end
                if (stall < 5) begin
                    checks++;
                    if (ov24 !== 1'b1 || mp24 !== held) begin
                        failures++;
                        $display("FAIL stall_hold: got valid=%b mp=%h expected valid=1 mp=%h", ov24, mp24, held);
                    end
                end
                held = mp24;
                stall--;
            end
            if (iv24 && ir24) begin
                expq.push_back(48'(pa[sent]) * 48'(pb[sent]));
                sent++;
            end
            if (ov24 && or24) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL bp_extra_result: got mp=%h expected no result", mp24);
                end else begin
                    if (mp24 !== expq[0]) begin
                        failures++;
                        $display("FAIL bp_result%0d: got %h expected %h", got, mp24, expq[0]);
                    end
                    expq.delete(0);
                end
                got++;
            end
            tick();
            guard++;
        end
        iv24 = 1'b0;
        or24 = 1'b1;
        checks++;
        if (got != 6 || sent != 6 || !stalled) begin
            failures++;
            $display("FAIL bp_count: got results=%0d sent=%0d stalled=%b expected 6/6/1", got, sent, stalled);
        end
        for (int t = 0; t < 3; t++) begin
            #1;
            checks++;
            if (ov24 !== 1'b0) begin failures++; $display("FAIL bp_duplicate: got valid=%b expected 0", ov24); end
            tick();
        end
    endtask

    task automatic test_reset_in_flight();
        logic [23:0] na, nb;
        int waited = 0;
        or24 = 1'b1;
        iv24 = 1'b1;
        a24  = 24'hABCDEF;
        b24  = 24'h876543;
        #1;
        tick();
        iv24 = 1'b0;
        while (ov24 !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        checks++;
        if (ov24 !== 1'b1) begin failures++; $display("FAIL rif_wait: got valid=%b expected 1 within 10 cycles", ov24); end
        rst = 1'b1;
        #1;
        checks++;
        if (ov24 !== 1'b0 || mp24 !== '0 || ir24 !== 1'b1) begin
            failures++;
            $display("FAIL rif_async_clear: got valid=%b mp=%h ready=%b expected 0/0/1", ov24, mp24, ir24);
        end
        tick();
        rst = 1'b0;
        tick();

        for (int t = 0; t < 3; t++) begin
            iv24 = 1'b1;
            a24  = 24'($urandom());
            b24  = 24'($urandom());
            tick();
        end
        iv24 = 1'b0;
        rst  = 1'b1;
        #1;
        checks++;
        if (ov24 !== 1'b0) begin failures++; $display("FAIL rif_pulse: got valid=%b expected 0", ov24); end
        tick();
        rst = 1'b0;
        for (int t = 0; t < 6; t++) begin
            #1;
            checks++;
            if (ov24 !== 1'b0) begin failures++; $display("FAIL rif_flushed t=%0d: got valid=%b expected 0", t, ov24); end
            tick();
        end

        na = 24'($urandom());
        nb = 24'($urandom());
        for (int u = 0; u <= L24 + 1; u++) begin
            iv24 = (u == 0);
            a24  = na;
            b24  = nb;
            #1;
            checks++;
            if (u == L24) begin
                if (ov24 !== 1'b1 || mp24 !== 48'(na) * 48'(nb)) begin
                    failures++;
                    $display("FAIL rif_first_after: got valid=%b mp=%h expected valid=1 mp=%h",
                             ov24, mp24, 48'(na) * 48'(nb));
                end
            end else if (ov24 !== 1'b0) begin
                failures++;
                $display("FAIL rif_latency u=%0d: got valid=%b expected 0", u, ov24);
            end
            tick();
        end
        iv24 = 1'b0;
    endtask

    task automatic test_random24();
        logic [47:0] expq [$];
        logic [47:0] prev_mp = '0;
        bit prev_stall = 1'b0;
        int guard = 0;
        for (int t = 0; t < 300 || (expq.size() > 0 && guard < 40); t++) begin
            if (t >= 300) guard++;
            iv24 = (t < 300) && ($urandom_range(3) != 0);
            or24 = (t >= 300) || ($urandom_range(3) != 0);
            a24  = 24'($urandom());
            b24  = 24'($urandom());
            #1;
            checks++;
            if (ir24 !== (!ov24 || or24)) begin
                failures++;
                $display("FAIL rnd_in_ready: got %b expected %b", ir24, (!ov24 || or24));
            end
            if (prev_stall) begin
                checks++;
                if (ov24 !== 1'b1 || mp24 !== prev_mp) begin
                    failures++;
                    $display("FAIL rnd_hold: got valid=%b mp=%h expected valid=1 mp=%h", ov24, mp24, prev_mp);
                end
            end
            if (iv24 && ir24) expq.push_back(48'(a24) * 48'(b24));
            if (ov24 && or24) begin
                checks++;
                if (expq.size() == 0 || mp24 !== expq[0] || nm24 !== expq[0][47]) begin
                    failures++;
                    $display("FAIL rnd_result: got mp=%h norm=%b expected mp=%h (pending=%0d)",
                             mp24, nm24, (expq.size() > 0) ? expq[0] : 48'h0, expq.size());
                end
                if (expq.size() > 0) expq.delete(0);
            end
            prev_stall = ov24 && !or24;
            prev_mp    = mp24;
            tick();
        end
        iv24 = 1'b0;
        or24 = 1'b1;
        checks++;
        if (expq.size() != 0) begin failures++; $display("FAIL rnd_drain: got pending=%0d expected 0", expq.size()); end
    endtask

    task automatic test_sweep53();
        exp_t q [$];
        exp_t e;
        int sent = 0;
        for (int t = 0; t < 2000 && (sent < 1000 || q.size() > 0); t++) begin
            if (sent < 1000 && (t % 3) != 2) begin
                iv53 = 1'b1;
                a53  = (sent == 0) ? '1 : (sent == 1) ? '0 : 53'({$urandom(), $urandom()});
                b53  = (sent < 2) ? '1 : 53'({$urandom(), $urandom()});
                e.cyc  = cyc + L53;
                e.prod = 106'(a53) * 106'(b53);
                q.push_back(e);
                sent++;
            end else begin
                iv53 = 1'b0;
            end
            #1;
            checks++;
            if (q.size() > 0 && q[0].cyc == cyc) begin
                if (ov53 !== 1'b1 || mp53 !== q[0].prod || nm53 !== q[0].prod[105]) begin
                    failures++;
                    $display("FAIL sweep53 cyc=%0d: got valid=%b mp=%h norm=%b expected valid=1 mp=%h norm=%b",
                             cyc, ov53, mp53, nm53, q[0].prod, q[0].prod[105]);
                end
                q.delete(0);
            end else if (ov53 !== 1'b0) begin
                failures++;
                $display("FAIL sweep53_gap cyc=%0d: got valid=%b expected 0", cyc, ov53);
            end
            tick();
        end
        iv53 = 1'b0;
        checks++;
        if (sent != 1000 || q.size() != 0) begin
            failures++;
            $display("FAIL sweep53_count: got sent=%0d pending=%0d expected 1000/0", sent, q.size());
        end
    endtask

    task automatic test_exhaustive8();
        exp_t q [$];
        exp_t e;
        int sent = 0;
        for (int t = 0; t < 65536 + 20 && (sent < 65536 || q.size() > 0); t++) begin
            if (sent < 65536) begin
                iv8 = 1'b1;
                a8  = sent[15:8];
                b8  = sent[7:0];
                e.cyc  = cyc + L8;
                e.prod = 106'(a8) * 106'(b8);
                q.push_back(e);
                sent++;
            end else begin
                iv8 = 1'b0;
            end
            #1;
            checks++;
            if (q.size() > 0 && q[0].cyc == cyc) begin
                if (ov8 !== 1'b1 || 106'(mp8) !== q[0].prod || nm8 !== q[0].prod[15]) begin
                    failures++;
                    $display("FAIL exh8 cyc=%0d: got valid=%b mp=%h norm=%b expected valid=1 mp=%h norm=%b",
                             cyc, ov8, mp8, nm8, q[0].prod[15:0], q[0].prod[15]);
                end
                q.delete(0);
            end else if (ov8 !== 1'b0) begin
                failures++;
                $display("FAIL exh8_idle cyc=%0d: got valid=%b expected 0", cyc, ov8);
            end
            tick();
        end
        iv8 = 1'b0;
        checks++;
        if (sent != 65536 || q.size() != 0) begin
            failures++;
            $display("FAIL exh8_count: got sent=%0d pending=%0d expected 65536/0", sent, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_boundary();
        test_backpressure();
        test_reset_in_flight();
        test_random24();
        test_sweep53();
        test_exhaustive8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "time limit reached");
    end
endmodule
